mpsoc_spram_memory: RTL and testbench



---
 rtl/mpsoc_spram_memory.sv | 169 ++++++++++++++++
 tb/tb_mpsoc_spram_memory.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mpsoc_spram_memory.sv
// Single-port byte-enabled SRAM behind the AXI4-to-SRAM adapter: zero-fill after
// reset, fixed read latency (1 or 2), and an error pulse on out-of-range accesses.
module mpsoc_spram_memory #(
    parameter int ADDR_WIDTH   = 64,
    parameter int DATA_WIDTH   = 64,
    parameter int MEM_DEPTH    = 1024,
    parameter int READ_LATENCY = 1,
    parameter int INIT_CLEAR   = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   data_i,
    output logic [DATA_WIDTH-1:0]   data_o,
    output logic                    rvalid_o,
    output logic                    err_o,
    output logic                    init_done_o
);
    localparam int NB   = DATA_WIDTH / 8;
    localparam int OFF  = $clog2(NB);
    localparam int IW   = $clog2(MEM_DEPTH);
    localparam int HI_W = ADDR_WIDTH - OFF - IW;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         init_cnt_q, init_cnt_d;
    logic                  clr_en;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [IW-1:0]         idx;
    logic                  oor;
    logic                  ready;
    logic                  wr_fire;
    logic                  rd_fire;

    logic [NB-1:0]         mem_be;
    logic [IW-1:0]         mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    logic                  s1_valid;
    logic                  s1_err;
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  wr_err_q;
    logic                  rd_err;

    assign idx = addr_i[OFF+IW-1:OFF];

    generate
        if (HI_W > 0) begin : g_range
            assign oor = |addr_i[ADDR_WIDTH-1:OFF+IW];
        end else begin : g_no_range
            assign oor = 1'b0;
        end

        // Byte-lane bits below the word index never select anything.
        if (OFF > 0) begin : g_lane_bits
            logic unused_lane_bits;
            assign unused_lane_bits = ^addr_i[OFF-1:0];
        end
    endgenerate

    assign ready       = (state_q == ST_READY);
    assign init_done_o = ready;
    assign wr_fire     = req_i & we_i & ready;
    assign rd_fire     = req_i & ~we_i & ready;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        clr_en     = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                if (INIT_CLEAR != 0) begin
                    clr_en     = ~rst_i;
                    init_cnt_d = init_cnt_q + 1'b1;
                    if (init_cnt_q == IW'(MEM_DEPTH - 1)) state_d = ST_READY;
                end else begin
                    state_d = ST_READY;
                end
            end
            ST_READY: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // The single write port is shared by the zero-fill and by requests.
    always_comb begin
        mem_be    = '0;
        mem_addr  = idx;
        mem_wdata = data_i;
        if (clr_en) begin
            mem_be    = '1;
            mem_addr  = init_cnt_q;
            mem_wdata = '0;
        end else if (wr_fire && !oor) begin
            mem_be = be_i;
        end
    end

    // NOTE: the array itself is not reset; clearing it is the job of the INIT fill.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NB; b++) begin
            if (mem_be[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_data  <= '0;
            wr_err_q <= 1'b0;
        end else begin
            s1_valid <= rd_fire;
            s1_err   <= rd_fire & oor;
            wr_err_q <= wr_fire & oor;
            if (rd_fire) s1_data <= oor ? '0 : mem[idx];
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  s2_valid;
            logic                  s2_err;
            logic [DATA_WIDTH-1:0] s2_data;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    s2_valid <= 1'b0;
                    s2_err   <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    s2_err   <= s1_err;
                    if (s1_valid) s2_data <= s1_data;
                end
            end

            assign rvalid_o = s2_valid;
            assign data_o   = s2_data;
            assign rd_err   = s2_err;
        end else begin : g_lat1
            assign rvalid_o = s1_valid;
            assign data_o   = s1_data;
            assign rd_err   = s1_err;
        end
    endgenerate

    // A write error and an older read error can land in the same cycle.
    assign err_o = wr_err_q | rd_err;
endmodule

// File: tb/tb_mpsoc_spram_memory.sv
// Directed bench for mpsoc_spram_memory: three instances cover latency 1/2,
// INIT_CLEAR 0/1 and a 1024-deep array for the out-of-range decode.
module tb_mpsoc_spram_memory;
    typedef struct packed {
        logic        rst;
        logic        req;
        logic        we;
        logic [63:0] addr;
        logic [7:0]  be;
        logic [63:0] data;
    } drv_t;

    logic  clk = 1'b0;
    drv_t  drv [3];
    int    n_checks = 0;
    int    n_errors = 0;

    logic [63:0] dout_a, dout_b, dout_c;
    logic        rvalid_a, rvalid_b, rvalid_c;
    logic        err_a, err_b, err_c;
    logic        done_a, done_b, done_c;

    always #5 clk = ~clk;

    mpsoc_spram_memory #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .MEM_DEPTH(16),
                         .READ_LATENCY(1), .INIT_CLEAR(1)) u_dut_a (
        .clk_i(clk), .rst_i(drv[0].rst), .req_i(drv[0].req), .we_i(drv[0].we),
        .addr_i(drv[0].addr), .be_i(drv[0].be), .data_i(drv[0].data),
        .data_o(dout_a), .rvalid_o(rvalid_a), .err_o(err_a), .init_done_o(done_a)
    );

    mpsoc_spram_memory #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .MEM_DEPTH(16),
                         .READ_LATENCY(2), .INIT_CLEAR(1)) u_dut_b (
        .clk_i(clk), .rst_i(drv[1].rst), .req_i(drv[1].req), .we_i(drv[1].we),
        .addr_i(drv[1].addr), .be_i(drv[1].be), .data_i(drv[1].data),
        .data_o(dout_b), .rvalid_o(rvalid_b), .err_o(err_b), .init_done_o(done_b)
    );

    mpsoc_spram_memory #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .MEM_DEPTH(1024),
                         .READ_LATENCY(1), .INIT_CLEAR(0)) u_dut_c (
        .clk_i(clk), .rst_i(drv[2].rst), .req_i(drv[2].req), .we_i(drv[2].we),
        .addr_i(drv[2].addr), .be_i(drv[2].be), .data_i(drv[2].data),
        .data_o(dout_c), .rvalid_o(rvalid_c), .err_o(err_c), .init_done_o(done_c)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // One active edge; returns at the following falling edge with outputs settled.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic idle(input int d);
        drv[d].req  = 1'b0;
        drv[d].we   = 1'b0;
        drv[d].addr = '0;
        drv[d].be   = '0;
        drv[d].data = '0;
    endtask

    task automatic wr(input int d, input logic [63:0] a, input logic [63:0] v, input logic [7:0] be);
        drv[d].req  = 1'b1;
        drv[d].we   = 1'b1;
        drv[d].addr = a;
        drv[d].be   = be;
        drv[d].data = v;
        tick(1);
        idle(d);
    endtask

    task automatic rd(input int d, input logic [63:0] a);
        drv[d].req  = 1'b1;
        drv[d].we   = 1'b0;
        drv[d].addr = a;
        tick(1);
        idle(d);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            idle(d);
            drv[d].rst = 1'b1;
        end
        tick(2);
        check("rst_dout_a", dout_a, 64'h0);
        check("rst_rvalid_a", rvalid_a, 1'b0);
        check("rst_err_a", err_a, 1'b0);
        check("rst_done_a", done_a, 1'b0);
        check("rst_done_c", done_c, 1'b0);
        check("rst_dout_b", dout_b, 64'h0);

        for (int d = 0; d < 3; d++) drv[d].rst = 1'b0;
        tick(1);
        check("noclear_done_c", done_c, 1'b1);
        check("fill_done_a_early", done_a, 1'b0);
        tick(15);
        check("fill_done_a", done_a, 1'b1);
        check("fill_done_b", done_b, 1'b1);

        // Byte enables and read-after-write on the latency-1 instance.
        wr(0, 64'h40, 64'h1122334455667788, 8'hFF);
        wr(0, 64'h40, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        check("wr_no_rvalid", rvalid_a, 1'b0);
        rd(0, 64'h40);
        check("be_rvalid", rvalid_a, 1'b1);
        check("be_data", dout_a, 64'h11223344AAAAAAAA);
        tick(1);
        check("be_pulse", rvalid_a, 1'b0);
        check("be_hold", dout_a, 64'h11223344AAAAAAAA);
        wr(0, 64'h40, 64'hFFFFFFFFFFFFFFFF, 8'h00);
        rd(0, 64'h40);
        check("be_zero_noop", dout_a, 64'h11223344AAAAAAAA);

        // Zero-fill after reset, with requests dropped during the fill.
        wr(0, 64'h28, 64'hDEADBEEF00000001, 8'hFF);
        rd(0, 64'h28);
        check("preload", dout_a, 64'hDEADBEEF00000001);
        drv[0].rst = 1'b1;
        tick(1);
        drv[0].rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            drv[0].req  = (k == 3) || (k == 5);
            drv[0].we   = (k == 5);
            drv[0].addr = (k == 5) ? 64'h100 : 64'h28;
            drv[0].be   = 8'hFF;
            tick(1);
            check($sformatf("fill_done_k%0d", k), done_a, k == 15);
            check($sformatf("fill_rvalid_k%0d", k), rvalid_a, 1'b0);
            check($sformatf("fill_err_k%0d", k), err_a, 1'b0);
        end
        idle(0);
        rd(0, 64'h28);
        check("fill_rvalid", rvalid_a, 1'b1);
        check("fill_cleared", dout_a, 64'h0);

        // Reset in the middle of the fill restarts it from word 0.
        drv[0].rst = 1'b1;
        tick(1);
        drv[0].rst = 1'b0;
        tick(7);
        drv[0].rst = 1'b1;
        tick(1);
        drv[0].rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tick(1);
            check($sformatf("refill_done_k%0d", k), done_a, k == 15);
        end

        // Pipelined reads on the latency-2 instance.
        for (int i = 0; i < 4; i++) wr(1, 64'(i * 8), 64'(16 + i), 8'hFF);
        for (int i = 0; i < 6; i++) begin
            drv[1].req  = (i < 4);
            drv[1].we   = 1'b0;
            drv[1].addr = 64'(i * 8);
            tick(1);
            check($sformatf("pipe_rvalid_%0d", i), rvalid_b, (i >= 1) && (i <= 4));
            if ((i >= 1) && (i <= 4)) check($sformatf("pipe_data_%0d", i), dout_b, 64'(15 + i));
        end
        idle(1);

        // Out-of-range on the latency-2 instance: write error early, read error with rvalid.
        wr(1, 64'h100, 64'hFF, 8'hFF);
        check("oor2_wr_err", err_b, 1'b1);
        rd(1, 64'h100);
        check("oor2_rd_err_early", err_b, 1'b0);
        check("oor2_rd_rvalid_early", rvalid_b, 1'b0);
        tick(1);
        check("oor2_rd_rvalid", rvalid_b, 1'b1);
        check("oor2_rd_err", err_b, 1'b1);
        check("oor2_rd_data", dout_b, 64'h0);

        // Reset one cycle after a read flushes it.
        drv[1].req  = 1'b1;
        drv[1].addr = 64'h8;
        tick(1);
        idle(1);
        drv[1].rst = 1'b1;
        tick(1);
        check("flush_rvalid_rst", rvalid_b, 1'b0);
        check("flush_dout_rst", dout_b, 64'h0);
        drv[1].rst = 1'b0;
        tick(1);
        check("flush_rvalid", rvalid_b, 1'b0);
        tick(15);
        check("flush_refill_done", done_b, 1'b1);

        // Out-of-range decode on the 1024-deep instance.
        wr(2, 64'h0, 64'h55, 8'hFF);
        wr(2, 64'h2000, 64'hFF, 8'hFF);
        check("oor_wr_err", err_c, 1'b1);
        check("oor_wr_rvalid", rvalid_c, 1'b0);
        tick(1);
        check("oor_err_pulse", err_c, 1'b0);
        rd(2, 64'h2000);
        check("oor_rd_rvalid", rvalid_c, 1'b1);
        check("oor_rd_data", dout_c, 64'h0);
        check("oor_rd_err", err_c, 1'b1);
        rd(2, 64'h0);
        check("oor_word0", dout_c, 64'h55);
        check("oor_word0_err", err_c, 1'b0);
        wr(2, 64'h1FF8, 64'hCAFE, 8'hFF);
        check("top_word_err", err_c, 1'b0);
        rd(2, 64'h1FFF);
        check("top_word_data", dout_c, 64'hCAFE);
        rd(2, 64'h8000000000000000);
        check("msb_err", err_c, 1'b1);
        check("msb_data", dout_c, 64'h0);

        // Without the fill, contents survive reset and the array is ready at once.
        drv[2].rst = 1'b1;
        tick(1);
        check("noclear_rst_done", done_c, 1'b0);
        drv[2].rst = 1'b0;
        tick(1);
        check("noclear_ready", done_c, 1'b1);
        rd(2, 64'h0);
        check("noclear_retain", dout_c, 64'h55);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
